// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Purpose:
//    Single-issue fetch stage. It holds a 5-bit PC and drives it straight
//    to a combinational instruction memory. Each accepted fetch is
//    registered into an output slot (out_instr/out_pc/out_valid) that uses
//    a valid/ready handshake with decode.
//
//    A redirect from execute flushes the slot and reloads the PC.
//    halt_req parks the stage in HALTED until the next redirect.
//    One BOOT cycle follows reset release before fetching begins.
//
// Ports:
//    clk              system clock, rising edge
//    rst_n            asynchronous active-low reset
//    imem_addr        word address to instruction memory (= pc)
//    imem_data        instruction returned combinationally for imem_addr
//    redirect_valid   jump / taken-branch request (ignored in BOOT)
//    redirect_target  new PC on redirect
//    halt_req         stop fetching (acted on in FETCH only)
//    out_valid        output slot holds a fetched instruction
//    out_ready        decode accepts the output slot this cycle
//    out_instr        registered instruction
//    out_pc           address of out_instr
//    halted           high while in HALTED
//    fetch_count      saturating count of instructions accepted by decode
// -----------------------------------------------------------------------------
module instruction_fetch (
   input  logic        clk,
   input  logic        rst_n,
   output logic [4:0]  imem_addr,
   input  logic [31:0] imem_data,
   input  logic        redirect_valid,
   input  logic [4:0]  redirect_target,
   input  logic        halt_req,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic [4:0]  out_pc,
   output logic        halted,
   output logic [7:0]  fetch_count
);

   typedef enum logic [1:0] {
      BOOT   = 2'd0,
      FETCH  = 2'd1,
      HALTED = 2'd2
   } state_e;

   state_e      state_q;
   logic [4:0]  pc_q;
   logic        out_valid_q;
   logic [31:0] out_instr_q;
   logic [4:0]  out_pc_q;
   logic        halted_q;
   logic [7:0]  fetch_count_q;
   logic [7:0]  fetch_count_d;
   logic        accept;

   // A handshake completes whenever the slot is valid and decode is ready.
   // This holds even in a redirect cycle, so a flushed-but-accepted entry
   // still counts.
   always_comb begin
      accept        = out_valid_q && out_ready;
      fetch_count_d = fetch_count_q;
      if (accept && (fetch_count_q != 8'hFF)) begin
         fetch_count_d = fetch_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= BOOT;
         pc_q          <= 5'd0;
         out_valid_q   <= 1'b0;
         out_instr_q   <= 32'd0;
         out_pc_q      <= 5'd0;
         halted_q      <= 1'b0;
         fetch_count_q <= 8'd0;
      end else begin
         fetch_count_q <= fetch_count_d;
         case (state_q)
            BOOT: begin
               // Redirect and halt are deliberately ignored here.
               state_q <= FETCH;
            end
            FETCH: begin
               if (redirect_valid) begin
                  pc_q        <= redirect_target;
                  out_valid_q <= 1'b0;
               end else if (halt_req) begin
                  // The pending entry stays visible until decode takes it.
                  state_q  <= HALTED;
                  halted_q <= 1'b1;
                  if (accept) begin
                     out_valid_q <= 1'b0;
                  end
               end else if (!out_valid_q || out_ready) begin
                  out_instr_q <= imem_data;
                  out_pc_q    <= pc_q;
                  out_valid_q <= 1'b1;
                  pc_q        <= pc_q + 5'd1;   // wraps 31 -> 0
               end
               // Otherwise this is a stall: everything holds.
            end
            HALTED: begin
               if (redirect_valid) begin
                  state_q     <= FETCH;
                  halted_q    <= 1'b0;
                  pc_q        <= redirect_target;
                  out_valid_q <= 1'b0;
               end else if (accept) begin
                  out_valid_q <= 1'b0;
               end
            end
            default: begin
               state_q  <= BOOT;
               halted_q <= 1'b0;
            end
         endcase
      end
   end

   assign imem_addr   = pc_q;
   assign out_valid   = out_valid_q;
   assign out_instr   = out_instr_q;
   assign out_pc      = out_pc_q;
   assign halted      = halted_q;
   assign fetch_count = fetch_count_q;

endmodule
